seq_control: RTL
================

SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter ALU_W, default 4: alu_control width; SHALL be >=4.
REQ-002 Parameter MEM_WAIT, default 1: 1 = memory states stall until mem_ready; 0 = mem_ready ignored, one cycle per memory state.
REQ-003 Parameter TRAP_EN, default 1: 1 = illegal opcode enters TRAP; 0 = illegal opcode returns to FETCH with no side effects.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 zero, lt, ltu  in  1 each  ALU flags: result==0, signed less-than, unsigned less-than.
REQ-007 op  in  7  opcode; funct3  in  3; funct7  in  1 (instruction bit 30).
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 Outputs, 1 bit each: pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal.
REQ-010 Outputs: result_src 2, alu_control ALU_W, alu_src_a 2, alu_src_b 2, imm_src 3, state_o 4 (current state, debug).

Function
REQ-011 Encodings: alu_src_a 0=PC,1=oldPC,2=rs1; alu_src_b 0=rs2,1=imm,2=const 4; result_src 0=ALUOut,1=Data,2=ALUResult; adr_src 0=PC,1=result; imm_src 0=I,1=S,2=B,3=J,4=U.
REQ-012 alu_control: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA, zero-extended to ALU_W.
REQ-013 Moore FSM, registered state; outputs combinational from state plus op/funct fields; unlisted outputs 0 (selects 0).
REQ-014 FETCH: mem_req=1, adr_src=0, ir_write=1, alu_src_a=0, alu_src_b=2, alu_control=ADD, result_src=2, pc_write=1; ir_write/pc_write only in the cycle mem_ready=1 (MEM_WAIT=1), else stay in FETCH; then DECODE.
REQ-015 DECODE: alu_src_a=1, alu_src_b=1, imm_src=2, ADD (branch target); next by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, else TRAP (TRAP_EN=1) / FETCH (TRAP_EN=0).
REQ-016 MEMADR: alu_src_a=2, alu_src_b=1, ADD, imm_src=I for load, S for store; next MEMREAD (load) or MEMWRITE (store).
REQ-017 MEMREAD: mem_req=1, adr_src=1, result_src=0; hold until mem_ready, then MEMWB. MEMWB: result_src=1, reg_write=1, then FETCH.
REQ-018 MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=0; hold until mem_ready, then FETCH. mem_write SHALL stay asserted every stall cycle.
REQ-019 EXECR: alu_src_a=2, alu_src_b=0; alu_control from funct3: 000 ADD/SUB(funct7), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA(funct7), 110 OR, 111 AND; then ALUWB.
REQ-020 EXECI: alu_src_a=2, alu_src_b=1, imm_src=I; decode as REQ-019 except funct3 000 always ADD, funct7 honoured only for 101; then ALUWB.
REQ-021 ALUWB: result_src=0, reg_write=1, then FETCH.
REQ-022 BRANCH: alu_src_a=2, alu_src_b=0, SUB, result_src=0; pc_write=taken, funct3 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu, 010/011 illegal (TRAP or FETCH per TRAP_EN, no pc_write); then FETCH.
REQ-023 JAL: alu_src_a=1, alu_src_b=2, ADD, result_src=0, pc_write=1 (target in ALUOut from DECODE with imm_src=J); then ALUWB. DECODE SHALL drive imm_src=J when op=1101111.
REQ-024 JALR: alu_src_a=2, alu_src_b=1, imm_src=I, ADD, result_src=2, pc_write=1; then JALR_LINK (alu_src_a=1, alu_src_b=2, ADD), then ALUWB.
REQ-025 LUI: result = imm (alu_src_a=2 forced by zero-rs1 convention not used; drive imm_src=U, alu_src_b=1, alu_control=ADD, alu_src_a=3 reserved-zero); AUIPC: alu_src_a=1, alu_src_b=1, imm_src=U, ADD; both then ALUWB.
REQ-026 TRAP: illegal=1, all write enables 0; held until reset_i.
REQ-027 MEM_WAIT=0: REQ-014/017/018 advance every cycle regardless of mem_ready.

Reset
REQ-028 reset_i=1 at a clock edge: state=FETCH next cycle from any state including mid-stall and TRAP; no write enable asserted during the reset cycle.
REQ-029 After reset all outputs equal FETCH values of REQ-014 with pc_write=ir_write=0 until mem_ready.

Verification
REQ-030 ADD x3,x1,x2 (op 0110011, f3 000, f7 0), mem_ready=1: states FETCH,DECODE,EXECR,ALUWB; reg_write=1 only in cycle 4.
REQ-031 LW with mem_ready low 3 cycles in MEMREAD: MEMREAD held 4 cycles, mem_req=1 throughout, MEMWB once.
REQ-032 BNE (f3 001) zero=0 -> pc_write=1 in BRANCH; zero=1 -> pc_write=0.
REQ-033 op=0000000, TRAP_EN=1 -> TRAP, illegal=1 held; reset_i -> FETCH. TRAP_EN=0 -> FETCH after DECODE, illegal=0.
REQ-034 SW stalled 2 cycles, reset_i asserted mid-stall -> FETCH next cycle, mem_write=0.
REQ-035 SRAI (op 0010011, f3 101, f7 1) -> alu_control=9; ADDI with f7 1 -> alu_control=0.

Source files
------------

// File: rtl/seq_control.sv
// Multicycle RV32I control sequencer: registered state, outputs decoded from the
// current state and the instruction fields held in the IR.
module seq_control #(
  parameter int unsigned ALU_W    = 4,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned TRAP_EN  = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [1:0]       result_src,
  output logic [ALU_W-1:0] alu_control,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       imm_src,
  output logic [3:0]       state_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  state_t     state;
  logic [3:0] alu_op;
  logic       mem_done;
  logic       br_ok;

  // Register/immediate arithmetic; funct7 picks SUB only for the register form.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7,
                                          input logic imm_form);
    logic [3:0] r;
    case (f3)
      3'b000:  r = (f7 && !imm_form) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic s, input logic u);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = s;
      3'b101:  t = !s;
      3'b110:  t = u;
      3'b111:  t = !u;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign mem_done    = (MEM_WAIT == 0) || mem_ready;
  assign br_ok       = (funct3[2:1] != 2'b01);
  assign state_o     = state;
  assign alu_control = ALU_W'(alu_op);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH:     if (mem_done) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_REG:            state <= S_EXECR;
            OP_IMM:            state <= S_EXECI;
            OP_BR:             state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI:            state <= S_LUI;
            OP_AUIPC:          state <= S_AUIPC;
            default:           state <= (TRAP_EN != 0) ? S_TRAP : S_FETCH;
          endcase
        end
        S_MEMADR:    state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:   if (mem_done) state <= S_MEMWB;
        S_MEMWB:     state <= S_FETCH;
        S_MEMWRITE:  if (mem_done) state <= S_FETCH;
        S_EXECR:     state <= S_ALUWB;
        S_EXECI:     state <= S_ALUWB;
        S_ALUWB:     state <= S_FETCH;
        S_BRANCH:    state <= (!br_ok && TRAP_EN != 0) ? S_TRAP : S_FETCH;
        S_JAL:       state <= S_ALUWB;
        S_JALR:      state <= S_JALR_LINK;
        S_JALR_LINK: state <= S_ALUWB;
        S_LUI:       state <= S_ALUWB;
        S_AUIPC:     state <= S_ALUWB;
        S_TRAP:      state <= S_TRAP;
      endcase
    end
  end

  // Datapath controls; write enables are forced low while reset is applied.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    alu_op     = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_write   = mem_done;
        ir_write   = mem_done;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = arith_op(funct3, funct7, 1'b0);
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = arith_op(funct3, funct7, 1'b1);
      end
      S_ALUWB:     reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        pc_write  = branch_taken(funct3, zero, lt, ltu);
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
      end
      S_TRAP:      illegal = 1'b1;
    endcase
    if (reset_i) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule
